// File: rtl/tl_ul_channel_buffer.sv
// TL-UL A/D channel buffer: each channel is either a wire passthrough (depth 0)
// or a registered ready/valid circular FIFO with an exported occupancy count.

module tl_ul_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [W-1:0]  enq_bits,
  output logic          deq_valid,
  input  logic          deq_ready,
  output logic [W-1:0]  deq_bits,
  output logic [CW-1:0] count
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign deq_valid = enq_valid;
      assign enq_ready = deq_ready;
      assign deq_bits  = enq_bits;
      assign count     = '0;
    end else begin : g_fifo
      localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

      logic [W-1:0]  r_mem [DEPTH];
      logic [PW-1:0] r_rd_ptr;
      logic [PW-1:0] r_wr_ptr;
      logic [CW-1:0] r_count;
      logic          w_enq_fire;
      logic          w_deq_fire;

      // Ready and valid come only from the count, so neither side sees the other combinationally.
      assign enq_ready  = (r_count != CW'(DEPTH));
      assign deq_valid  = (r_count != '0);
      assign deq_bits   = r_mem[r_rd_ptr];
      assign count      = r_count;
      assign w_enq_fire = enq_valid && enq_ready;
      assign w_deq_fire = deq_valid && deq_ready;

      // Payload storage is deliberately left out of reset.
      always_ff @(posedge clock) begin
        if (w_enq_fire) begin
          r_mem[r_wr_ptr] <= enq_bits;
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_rd_ptr <= '0;
          r_wr_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_enq_fire) begin
            r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
          end
          if (w_deq_fire) begin
            r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
          end
          if (w_enq_fire && !w_deq_fire) begin
            r_count <= r_count + CW'(1);
          end else if (!w_enq_fire && w_deq_fire) begin
            r_count <= r_count - CW'(1);
          end
        end
      end
    end
  endgenerate

endmodule

module tl_ul_channel_buffer #(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  parameter  int SIZE_W  = 4,
  parameter  int SRC_W   = 1,
  parameter  int A_DEPTH = 2,
  parameter  int D_DEPTH = 2,
  localparam int A_W     = 7 + SIZE_W + SRC_W + ADDR_W + DATA_W / 8 + DATA_W,
  localparam int D_W     = 8 + SIZE_W + SRC_W + DATA_W,
  localparam int A_CW    = (A_DEPTH == 0) ? 1 : $clog2(A_DEPTH + 1),
  localparam int D_CW    = (D_DEPTH == 0) ? 1 : $clog2(D_DEPTH + 1)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_a_valid,
  output logic            in_a_ready,
  input  logic [A_W-1:0]  in_a_bits,
  output logic            out_a_valid,
  input  logic            out_a_ready,
  output logic [A_W-1:0]  out_a_bits,
  input  logic            out_d_valid,
  output logic            out_d_ready,
  input  logic [D_W-1:0]  out_d_bits,
  output logic            in_d_valid,
  input  logic            in_d_ready,
  output logic [D_W-1:0]  in_d_bits,
  output logic [A_CW-1:0] a_count,
  output logic [D_CW-1:0] d_count
);

  tl_ul_fifo #(.W(A_W), .DEPTH(A_DEPTH), .CW(A_CW)) u_a_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .enq_valid (in_a_valid),
    .enq_ready (in_a_ready),
    .enq_bits  (in_a_bits),
    .deq_valid (out_a_valid),
    .deq_ready (out_a_ready),
    .deq_bits  (out_a_bits),
    .count     (a_count)
  );

  // D flows slave -> master, so the enqueue side is the out_d port.
  tl_ul_fifo #(.W(D_W), .DEPTH(D_DEPTH), .CW(D_CW)) u_d_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .enq_valid (out_d_valid),
    .enq_ready (out_d_ready),
    .enq_bits  (out_d_bits),
    .deq_valid (in_d_valid),
    .deq_ready (in_d_ready),
    .deq_bits  (in_d_bits),
    .count     (d_count)
  );

endmodule

// File: tb/tb_tl_ul_channel_buffer.sv
// Bench for tl_ul_channel_buffer: a buffered instance (A depth 2, D depth 3)
// and a passthrough instance (both depths 0), checked against a queue scoreboard.

module tb_tl_ul_channel_buffer;

  localparam int A_W = 80;
  localparam int D_W = 45;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           in_a_valid, in_a_ready, out_a_valid, out_a_ready;
  logic [A_W-1:0] in_a_bits, out_a_bits;
  logic           out_d_valid, out_d_ready, in_d_valid, in_d_ready;
  logic [D_W-1:0] out_d_bits, in_d_bits;
  logic [1:0]     a_count, d_count;

  logic           p_in_a_valid, p_in_a_ready, p_out_a_valid, p_out_a_ready;
  logic [A_W-1:0] p_in_a_bits, p_out_a_bits;
  logic           p_out_d_valid, p_out_d_ready, p_in_d_valid, p_in_d_ready;
  logic [D_W-1:0] p_out_d_bits, p_in_d_bits;
  logic [0:0]     p_a_count, p_d_count;

  int checks = 0;
  int failures = 0;
  int a_cnt = 0;
  int d_cnt = 0;
  logic [A_W-1:0] a_q[$];
  logic [D_W-1:0] d_q[$];

  always #5 clock = ~clock;

  tl_ul_channel_buffer #(.A_DEPTH(2), .D_DEPTH(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_bits(in_a_bits),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_bits(out_a_bits),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_bits(out_d_bits),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_bits(in_d_bits),
    .a_count(a_count), .d_count(d_count)
  );

  tl_ul_channel_buffer #(.A_DEPTH(0), .D_DEPTH(0)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .in_a_valid(p_in_a_valid), .in_a_ready(p_in_a_ready), .in_a_bits(p_in_a_bits),
    .out_a_valid(p_out_a_valid), .out_a_ready(p_out_a_ready), .out_a_bits(p_out_a_bits),
    .out_d_valid(p_out_d_valid), .out_d_ready(p_out_d_ready), .out_d_bits(p_out_d_bits),
    .in_d_valid(p_in_d_valid), .in_d_ready(p_in_d_ready), .in_d_bits(p_in_d_bits),
    .a_count(p_a_count), .d_count(p_d_count)
  );

  function automatic logic [A_W-1:0] mk_a(int i);
    return {3'd4, 3'd0, 4'd2, 1'b0, 32'h1000 + 32'(i * 4), 4'hF, 32'hA500_0000 + 32'(i), 1'b0};
  endfunction

  function automatic logic [D_W-1:0] mk_d(int i);
    return {3'd1, 2'd0, 4'd2, 1'b0, 1'b0, 1'b0, 32'(i), 1'b0};
  endfunction

  task automatic test_reset();
    @(negedge clock);
    checks++; if (out_a_valid !== 1'b0) begin failures++; $display("FAIL rst_out_a_valid got=%b exp=0", out_a_valid); end
    checks++; if (in_d_valid !== 1'b0) begin failures++; $display("FAIL rst_in_d_valid got=%b exp=0", in_d_valid); end
    checks++; if (a_count !== 2'd0) begin failures++; $display("FAIL rst_a_count got=%0d exp=0", a_count); end
    checks++; if (d_count !== 2'd0) begin failures++; $display("FAIL rst_d_count got=%0d exp=0", d_count); end
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (in_a_ready !== 1'b1) begin failures++; $display("FAIL rst_in_a_ready got=%b exp=1", in_a_ready); end
    checks++; if (out_d_ready !== 1'b1) begin failures++; $display("FAIL rst_out_d_ready got=%b exp=1", out_d_ready); end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    logic [A_W-1:0] exp;
    out_a_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_a_valid = (c < 3);
      in_a_bits  = mk_a(c);
      @(negedge clock);
      checks++; if (out_a_valid !== (c >= 1 && c <= 3)) begin failures++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, out_a_valid, (c >= 1 && c <= 3)); end
      checks++; if (a_count !== ((c >= 1 && c <= 3) ? 2'd1 : 2'd0)) begin failures++; $display("FAIL b2b_count c=%0d got=%0d", c, a_count); end
      checks++; if (in_a_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready c=%0d got=%b exp=1", c, in_a_ready); end
      if (out_a_valid === 1'b1) begin
        checks++;
        if (a_q.size() == 0) begin failures++; $display("FAIL b2b_unexpected c=%0d got=%h", c, out_a_bits); end
        else begin
          exp = a_q.pop_front();
          if (out_a_bits !== exp) begin failures++; $display("FAIL b2b_bits c=%0d got=%h exp=%h", c, out_a_bits, exp); end
        end
      end
      if (c < 3) a_q.push_back(mk_a(c));
      @(posedge clock); #1;
    end
    in_a_valid = 1'b0;
    checks++; if (a_q.size() != 0) begin failures++; $display("FAIL b2b_leftover got=%0d exp=0", a_q.size()); end
    a_q.delete();
    a_cnt = 0;
  endtask

  task automatic test_backpressure();
    logic [A_W-1:0] exp;
    bit ein, eout;
    int sent = 0;
    int got = 0;
    out_a_ready = 1'b0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      if (c == 6) out_a_ready = 1'b1;
      in_a_valid = (sent < 3);
      in_a_bits  = mk_a(10 + sent);
      @(negedge clock);
      checks++; if (in_a_ready !== (a_cnt != 2)) begin failures++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, in_a_ready, (a_cnt != 2)); end
      checks++; if (out_a_valid !== (a_cnt != 0)) begin failures++; $display("FAIL bp_valid c=%0d got=%b exp=%b", c, out_a_valid, (a_cnt != 0)); end
      checks++; if (a_count !== 2'(a_cnt)) begin failures++; $display("FAIL bp_count c=%0d got=%0d exp=%0d", c, a_count, a_cnt); end
      ein  = in_a_valid && (a_cnt != 2);
      eout = out_a_ready && (a_cnt != 0);
      if (eout) begin
        exp = a_q.pop_front();
        got++;
        checks++; if (out_a_bits !== exp) begin failures++; $display("FAIL bp_bits c=%0d got=%h exp=%h", c, out_a_bits, exp); end
      end
      if (ein) begin a_q.push_back(in_a_bits); sent++; end
      a_cnt = a_cnt + int'(ein) - int'(eout);
      @(posedge clock); #1;
    end
    in_a_valid = 1'b0;
    checks++; if (got != 3) begin failures++; $display("FAIL bp_timeout got=%0d exp=3", got); end
  endtask

  task automatic test_d_nonpow2();
    logic [D_W-1:0] exp;
    bit ein, eout;
    int sent = 0;
    int got = 0;
    for (int c = 0; c < 300 && got < 7; c++) begin
      out_d_valid = (sent < 7) && ($urandom_range(0, 3) != 0);
      out_d_bits  = mk_d(sent);
      in_d_ready  = ($urandom_range(0, 2) != 0);
      @(negedge clock);
      checks++; if (out_d_ready !== (d_cnt != 3)) begin failures++; $display("FAIL d3_ready c=%0d got=%b exp=%b", c, out_d_ready, (d_cnt != 3)); end
      checks++; if (in_d_valid !== (d_cnt != 0)) begin failures++; $display("FAIL d3_valid c=%0d got=%b exp=%b", c, in_d_valid, (d_cnt != 0)); end
      checks++; if (d_count !== 2'(d_cnt)) begin failures++; $display("FAIL d3_count c=%0d got=%0d exp=%0d", c, d_count, d_cnt); end
      ein  = out_d_valid && (d_cnt != 3);
      eout = in_d_ready && (d_cnt != 0);
      if (eout) begin
        exp = d_q.pop_front();
        got++;
        checks++; if (in_d_bits !== exp) begin failures++; $display("FAIL d3_bits c=%0d got=%h exp=%h", c, in_d_bits, exp); end
      end
      if (ein) begin d_q.push_back(out_d_bits); sent++; end
      d_cnt = d_cnt + int'(ein) - int'(eout);
      @(posedge clock); #1;
    end
    out_d_valid = 1'b0;
    in_d_ready  = 1'b1;
    checks++; if (got != 7) begin failures++; $display("FAIL d3_timeout got=%0d exp=7", got); end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 16; i++) begin
      p_in_a_valid  = 1'($urandom);
      p_out_a_ready = 1'($urandom);
      p_in_a_bits   = {16'($urandom), $urandom, $urandom};
      p_out_d_valid = 1'($urandom);
      p_in_d_ready  = 1'($urandom);
      p_out_d_bits  = {13'($urandom), $urandom};
      #1;
      checks++; if (p_out_a_valid !== p_in_a_valid) begin failures++; $display("FAIL pt_a_valid i=%0d got=%b exp=%b", i, p_out_a_valid, p_in_a_valid); end
      checks++; if (p_in_a_ready !== p_out_a_ready) begin failures++; $display("FAIL pt_a_ready i=%0d got=%b exp=%b", i, p_in_a_ready, p_out_a_ready); end
      checks++; if (p_out_a_bits !== p_in_a_bits) begin failures++; $display("FAIL pt_a_bits i=%0d got=%h exp=%h", i, p_out_a_bits, p_in_a_bits); end
      checks++; if (p_in_d_valid !== p_out_d_valid) begin failures++; $display("FAIL pt_d_valid i=%0d got=%b exp=%b", i, p_in_d_valid, p_out_d_valid); end
      checks++; if (p_out_d_ready !== p_in_d_ready) begin failures++; $display("FAIL pt_d_ready i=%0d got=%b exp=%b", i, p_out_d_ready, p_in_d_ready); end
      checks++; if (p_in_d_bits !== p_out_d_bits) begin failures++; $display("FAIL pt_d_bits i=%0d got=%h exp=%h", i, p_in_d_bits, p_out_d_bits); end
      checks++; if (p_a_count !== 1'b0 || p_d_count !== 1'b0) begin failures++; $display("FAIL pt_counts i=%0d got=%b/%b exp=0/0", i, p_a_count, p_d_count); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_independence();
    logic [D_W-1:0] exp;
    out_a_ready = 1'b0;
    in_d_ready  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_a_valid = 1'b1;
      in_a_bits  = mk_a(20 + c);
      a_q.push_back(mk_a(20 + c));
      @(posedge clock); #1;
    end
    in_a_bits = mk_a(22);
    a_cnt = 2;
    for (int c = 0; c < 7; c++) begin
      out_d_valid = (c < 4);
      out_d_bits  = mk_d(100 + c);
      @(negedge clock);
      checks++; if (in_a_ready !== 1'b0 || a_count !== 2'd2) begin failures++; $display("FAIL ind_a_stall c=%0d got=%b/%0d exp=0/2", c, in_a_ready, a_count); end
      checks++; if (out_d_ready !== 1'b1) begin failures++; $display("FAIL ind_d_ready c=%0d got=%b exp=1", c, out_d_ready); end
      checks++; if (in_d_valid !== (c >= 1 && c <= 4)) begin failures++; $display("FAIL ind_d_valid c=%0d got=%b exp=%b", c, in_d_valid, (c >= 1 && c <= 4)); end
      if (in_d_valid === 1'b1 && d_q.size() != 0) begin
        exp = d_q.pop_front();
        checks++; if (in_d_bits !== exp) begin failures++; $display("FAIL ind_d_bits c=%0d got=%h exp=%h", c, in_d_bits, exp); end
      end
      if (c < 4) d_q.push_back(mk_d(100 + c));
      @(posedge clock); #1;
    end
    out_d_valid = 1'b0;
    checks++; if (d_q.size() != 0) begin failures++; $display("FAIL ind_d_leftover got=%0d exp=0", d_q.size()); end
  endtask

  task automatic test_reset_midcycle();
    in_a_valid = 1'b0;
    @(negedge clock);
    checks++; if (a_count !== 2'd2 || out_a_valid !== 1'b1) begin failures++; $display("FAIL mr_prefill got=%0d/%b exp=2/1", a_count, out_a_valid); end
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    checks++; if (out_a_valid !== 1'b0) begin failures++; $display("FAIL mr_valid got=%b exp=0", out_a_valid); end
    checks++; if (a_count !== 2'd0) begin failures++; $display("FAIL mr_count got=%0d exp=0", a_count); end
    checks++; if (in_a_ready !== 1'b1) begin failures++; $display("FAIL mr_ready got=%b exp=1", in_a_ready); end
    #2;
    reset_n = 1'b1;
    a_q.delete();
    a_cnt = 0;
    out_a_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++; if (out_a_valid !== 1'b0) begin failures++; $display("FAIL mr_stale c=%0d got=%b exp=0", c, out_a_valid); end
    end
    @(posedge clock); #1;
    in_a_valid = 1'b1;
    in_a_bits  = mk_a(50);
    a_q.push_back(mk_a(50));
    @(negedge clock);
    checks++; if (out_a_valid !== 1'b0) begin failures++; $display("FAIL mr_flowthrough got=%b exp=0", out_a_valid); end
    @(posedge clock); #1;
    in_a_valid = 1'b0;
    @(negedge clock);
    checks++; if (out_a_valid !== 1'b1 || out_a_bits !== a_q[0]) begin failures++; $display("FAIL mr_new_beat got=%b/%h exp=1/%h", out_a_valid, out_a_bits, a_q[0]); end
    void'(a_q.pop_front());
    @(negedge clock);
    checks++; if (out_a_valid !== 1'b0) begin failures++; $display("FAIL mr_after got=%b exp=0", out_a_valid); end
  endtask

  initial begin
    reset_n = 1'b0;
    in_a_valid = 1'b0; in_a_bits = '0; out_a_ready = 1'b0;
    out_d_valid = 1'b0; out_d_bits = '0; in_d_ready = 1'b1;
    p_in_a_valid = 1'b0; p_in_a_bits = '0; p_out_a_ready = 1'b0;
    p_out_d_valid = 1'b0; p_out_d_bits = '0; p_in_d_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_d_nonpow2();
    test_passthrough();
    test_independence();
    test_reset_midcycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
